// File: rtl/layered_rgb_mux.sv
// Layered RGB priority compositor for the VGA path.
// Two-stage pipeline: stage 1 registers the pixel inputs and the per-layer hit vector.
// Stage 2 registers the composited colour and accumulates per-frame layer collisions.
// Layer enables are shadowed at startOfFrame, so an enable change never takes effect mid-frame.

// Per-layer hit qualifier: drawing request, enabled, and not the transparent key colour.
module layer_hit_lane #(
    parameter int               RGB_W      = 8,
    parameter logic [RGB_W-1:0] TRANSP_KEY = 8'hFF,
    parameter bit               TRANSP_EN  = 1'b1
) (
    input  logic             dr,
    input  logic             en,
    input  logic [RGB_W-1:0] rgb,
    output logic             hit
);
    // A transparent pixel behaves as if the layer did not request to draw.
    always_comb begin
        hit = dr & en & ~(TRANSP_EN && (rgb == TRANSP_KEY));
    end
endmodule

module layered_rgb_mux #(
    parameter int               NUM_LAYERS = 8,
    parameter int               RGB_W      = 8,
    parameter logic [RGB_W-1:0] TRANSP_KEY = 8'hFF,
    parameter bit               TRANSP_EN  = 1'b1
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       layer_en_req,
    input  logic [NUM_LAYERS-1:0]       layer_dr,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic                        overlay_dr,
    input  logic [RGB_W-1:0]            overlay_rgb,
    input  logic [RGB_W-1:0]            background_rgb,
    output logic [RGB_W-1:0]            RGBOut,
    output logic [NUM_LAYERS-1:0]       layer_en_active,
    output logic [NUM_LAYERS-1:0]       collision_mask,
    output logic                        collision_valid
);
    // Flat colour bus viewed as one RGB_W element per layer (layer i at [i*RGB_W +: RGB_W]).
    logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb_arr;
    logic [NUM_LAYERS-1:0]            hit;

    assign rgb_arr = layer_rgb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_lane
            layer_hit_lane #(
                .RGB_W     (RGB_W),
                .TRANSP_KEY(TRANSP_KEY),
                .TRANSP_EN (TRANSP_EN)
            ) u_lane (
                .dr (layer_dr[gi]),
                .en (layer_en_active[gi]),
                .rgb(rgb_arr[gi]),
                .hit(hit[gi])
            );
        end
    endgenerate

    // Stage 1 registers
    logic [NUM_LAYERS-1:0]            s1_hit;
    logic [NUM_LAYERS-1:0][RGB_W-1:0] s1_rgb;
    logic                             s1_ov_dr;
    logic [RGB_W-1:0]                 s1_ov_rgb;
    logic [RGB_W-1:0]                 s1_bg;

    // Collision accumulator for the frame in progress
    logic [NUM_LAYERS-1:0] coll_acc;
    logic [NUM_LAYERS-1:0] coll_contrib;
    logic                  multi_hit;
    logic [RGB_W-1:0]      pix;

    // Enable shadow: only loaded on the first pixel of a frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)           layer_en_active <= '0;
        else if (startOfFrame) layer_en_active <= layer_en_req;
    end

    // Stage 1: capture pixel inputs and the qualified hit vector.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_hit    <= '0;
            s1_rgb    <= '0;
            s1_ov_dr  <= 1'b0;
            s1_ov_rgb <= '0;
            s1_bg     <= '0;
        end else begin
            s1_hit    <= hit;
            s1_rgb    <= rgb_arr;
            s1_ov_dr  <= overlay_dr;
            s1_ov_rgb <= overlay_rgb;
            s1_bg     <= background_rgb;
        end
    end

    // Priority select: overlay first, then the lowest-index hit layer, else background.
    always_comb begin
        pix = s1_bg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_hit[i]) pix = s1_rgb[i];
        end
        if (s1_ov_dr) pix = s1_ov_rgb;
    end

    // Two or more hits in the same pixel: clearing the lowest set bit leaves something.
    always_comb begin
        multi_hit    = |(s1_hit & (s1_hit - NUM_LAYERS'(1)));
        coll_contrib = multi_hit ? s1_hit : '0;
    end

    // Stage 2: composited output.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) RGBOut <= '0;
        else         RGBOut <= pix;
    end

    // Collision accumulation; publish and restart at each frame start.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_acc        <= '0;
            collision_mask  <= '0;
            collision_valid <= 1'b0;
        end else if (startOfFrame) begin
            collision_mask  <= coll_acc | coll_contrib;
            coll_acc        <= '0;
            collision_valid <= 1'b1;
        end else begin
            coll_acc        <= coll_acc | coll_contrib;
            collision_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_layered_rgb_mux.sv
// Directed bench for layered_rgb_mux: a streamed vector table plus hand-written
// sequences for enable shadowing, collision publication and mid-frame reset.
module tb_layered_rgb_mux;
    logic        clk = 1'b0;
    logic        resetN;
    logic        sof;
    logic [7:0]  en_req;
    logic [7:0]  dr;
    logic [63:0] rgb;
    logic        ov_dr;
    logic [7:0]  ov_rgb;
    logic [7:0]  bg;
    logic [7:0]  rgb_out, en_act, cmask;
    logic        cvalid;
    logic [7:0]  rgb_out2, en_act2, cmask2;
    logic        cvalid2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    layered_rgb_mux dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .layer_en_req(en_req),
        .layer_dr(dr), .layer_rgb(rgb), .overlay_dr(ov_dr), .overlay_rgb(ov_rgb),
        .background_rgb(bg), .RGBOut(rgb_out), .layer_en_active(en_act),
        .collision_mask(cmask), .collision_valid(cvalid)
    );

    layered_rgb_mux #(.TRANSP_EN(1'b0)) dut_nt (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .layer_en_req(en_req),
        .layer_dr(dr), .layer_rgb(rgb), .overlay_dr(ov_dr), .overlay_rgb(ov_rgb),
        .background_rgb(bg), .RGBOut(rgb_out2), .layer_en_active(en_act2),
        .collision_mask(cmask2), .collision_valid(cvalid2)
    );

    typedef struct {
        logic [7:0]  dr;
        logic [63:0] rgb;
        logic        ov;
        logic [7:0]  ov_rgb;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dr    = 8'h00;
        ov_dr = 1'b0;
        sof   = 1'b0;
        rgb   = 64'h0;
    endtask

    task automatic sof_pulse(input logic [7:0] en);
        sof    = 1'b1;
        en_req = en;
        step();
        sof    = 1'b0;
    endtask

    initial begin
        // dr, rgb (layer7 .. layer0 bytes), overlay, overlay colour, expected
        vt[0] = '{8'h28, 64'h0000E0001C000000, 1'b0, 8'h00, 8'h1C};
        vt[1] = '{8'h28, 64'h0000E000FF000000, 1'b0, 8'h00, 8'hE0};
        vt[2] = '{8'h28, 64'h0000E0001C000000, 1'b1, 8'h03, 8'h03};
        vt[3] = '{8'h00, 64'h0000E0001C000000, 1'b0, 8'h00, 8'h25};
        vt[4] = '{8'h80, 64'h4400000000000000, 1'b0, 8'h00, 8'h44};
        vt[5] = '{8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 8'h00, 8'h25};
        vt[6] = '{8'h05, 64'h0000000000220011, 1'b0, 8'h00, 8'h11};

        resetN = 1'b0;
        en_req = 8'h00;
        ov_rgb = 8'h00;
        bg     = 8'h25;
        idle();
        step();
        step();
        chk("reset_rgb",   rgb_out, 8'h00);
        chk("reset_en",    en_act,  8'h00);
        chk("reset_mask",  cmask,   8'h00);
        chk("reset_valid", cvalid,  1'b0);
        resetN = 1'b1;
        step();

        // Enable all layers.
        sof_pulse(8'hFF);
        chk("sof_en",    en_act, 8'hFF);
        chk("sof_valid", cvalid, 1'b1);
        chk("sof_mask",  cmask,  8'h00);
        step();
        chk("valid_drop", cvalid, 1'b0);

        // Stream the table one pixel per clock; output trails input by two clocks.
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) begin
                dr = vt[k].dr; rgb = vt[k].rgb; ov_dr = vt[k].ov; ov_rgb = vt[k].ov_rgb;
            end else begin
                idle();
            end
            step();
            if (k >= 1) chk($sformatf("vec%0d", k - 1), rgb_out, vt[k-1].exp);
            if (k == 2) chk("no_transp_key", rgb_out2, 8'hFF);
        end
        idle();
        step();
        step();

        // Frame collisions: layers 3,5 (incl. under overlay) and 0,2.
        sof_pulse(8'hFF);
        chk("frame_mask_2d", cmask, 8'h2D);
        chk("frame_valid", cvalid, 1'b1);
        step();
        chk("frame_valid_drop", cvalid, 1'b0);

        // Single-pixel overlap of layers 0 and 2.
        dr = 8'h05; rgb = 64'h0000000000220011;
        step();
        idle();
        step();
        chk("overlap_rgb", rgb_out, 8'h11);
        step();
        sof_pulse(8'hFF);
        chk("mask_05", cmask, 8'h05);
        chk("mask_05_valid", cvalid, 1'b1);
        step();
        step();
        sof_pulse(8'hFF);
        chk("mask_clear", cmask, 8'h00);

        // Mid-frame enable request is ignored until the next frame start.
        en_req = 8'h00;
        dr = 8'h08; rgb = 64'h000000001C000000;
        step();
        step();
        chk("midframe_en_ignored", rgb_out, 8'h1C);
        // Pixel on the frame-start cycle still uses the old enables.
        sof = 1'b1;
        step();
        sof = 1'b0;
        step();
        chk("sof_pixel_old_en", rgb_out, 8'h1C);
        chk("en_now_zero", en_act, 8'h00);
        step();
        chk("disabled_bg", rgb_out, 8'h25);
        idle();

        // Back-to-back frame starts: second publishes a single pixel's collisions.
        sof_pulse(8'hFF);
        step();
        step();
        sof = 1'b1; en_req = 8'hFF; dr = 8'h05; rgb = 64'h0000000000220011;
        step();
        dr = 8'h00;
        step();
        chk("double_sof_mask", cmask, 8'h05);
        chk("double_sof_valid", cvalid, 1'b1);
        sof = 1'b0;
        step();
        chk("double_sof_drop", cvalid, 1'b0);

        // Asynchronous reset in the middle of a frame.
        dr = 8'h08; rgb = 64'h000000001C000000;
        step();
        step();
        chk("pre_reset_rgb", rgb_out, 8'h1C);
        #2 resetN = 1'b0;
        #1;
        chk("async_rst_rgb",   rgb_out, 8'h00);
        chk("async_rst_en",    en_act,  8'h00);
        chk("async_rst_mask",  cmask,   8'h00);
        chk("async_rst_valid", cvalid,  1'b0);
        step();
        resetN = 1'b1;
        step();
        step();
        chk("post_reset_bg", rgb_out, 8'h25);
        chk("post_reset_en", en_act,  8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
